// File: rtl/gat_mem_pkg.sv
// Shared URAM constants and fetch controller state encoding.
package gat_mem_pkg;

   localparam int URAM_DATA_WIDTH = 19;
   localparam int URAM_DEPTH      = 242101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/uram_fetch_ctrl_if.sv
// Command, URAM read port and output stream bundle for the fetch controller.
interface uram_fetch_ctrl_if
   import gat_mem_pkg::*;
#(
   parameter int DATA_WIDTH = URAM_DATA_WIDTH,
   parameter int DEPTH      = URAM_DEPTH
);
   localparam int DATA_ADDR_W = $clog2(DEPTH);
   localparam int LEN_W       = DATA_ADDR_W + 1;

   logic                   start;
   logic [DATA_ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]       len;
   logic                   busy;
   logic                   done;
   logic [DATA_ADDR_W-1:0] addrb;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic [DATA_WIDTH-1:0]  out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;

   // Command source, URAM model and stream sink side
   modport master (
      output start, base_addr, len, rd_data, out_ready,
      input  busy, done, addrb, out_data, out_valid, out_last
   );

   // Controller side
   modport slave (
      input  start, base_addr, len, rd_data, out_ready,
      output busy, done, addrb, out_data, out_valid, out_last
   );

endinterface

// File: rtl/uram_fetch_ctrl_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop in the same
// cycle are both honoured. Output is forced to zero while empty.
module fetch_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_rd;
   logic             w_wr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign w_rd    = i_pop & ~o_empty;
   assign w_wr    = i_push & (~o_full | w_rd);
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage write; contents need no reset since reads are gated by count
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_din;
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule

// File: rtl/uram_fetch_ctrl.sv
// URAM read-side fetch controller: turns a (base, len) command into
// sequential reads, tracks read latency with a tag pipe and streams the
// returned words through a credit-protected skid FIFO.
module uram_fetch_ctrl
   import gat_mem_pkg::*;
#(
   parameter int DATA_WIDTH  = URAM_DATA_WIDTH,
   parameter int DEPTH       = URAM_DEPTH,
   parameter int DATA_ADDR_W = $clog2(DEPTH),
   parameter int LEN_W       = DATA_ADDR_W + 1,
   parameter int RD_LATENCY  = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic clk,
   input  logic rst,
   uram_fetch_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("uram_fetch_ctrl: RD_LATENCY must be 1, 2 or 3");
   end
   if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_fifo_depth
      $error("uram_fetch_ctrl: FIFO_DEPTH must be at least RD_LATENCY+1");
   end

   fetch_state_e           r_state;
   fetch_state_e           w_state_nxt;
   logic [DATA_ADDR_W-1:0] r_addr;
   logic [DATA_ADDR_W-1:0] r_addrb;
   logic [LEN_W-1:0]       r_remain;
   logic                   r_done;
   // vld_pipe[0] travels with addrb; vld_pipe[RD_LATENCY] lines up with rd_data
   logic [RD_LATENCY:0]    r_vld_pipe;
   logic [RD_LATENCY:0]    r_last_pipe;

   logic                   w_issue;
   logic                   w_tag_last;
   logic [DATA_ADDR_W-1:0] w_issue_addr;
   logic                   w_done_nxt;
   logic                   w_credit_ok;
   logic                   w_pop;
   logic                   w_empty;
   logic                   w_full;
   logic [CNT_W-1:0]       w_fifo_cnt;
   logic [DATA_WIDTH:0]    w_head;
   int                     w_inflight;

   function automatic logic [DATA_ADDR_W-1:0] addr_inc(input logic [DATA_ADDR_W-1:0] a);
      return (a == DATA_ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   assign w_pop = ~w_empty & bus.out_ready;

   // Credit: everything issued and not yet popped must fit in the FIFO
   always_comb begin
      w_inflight = 0;
      for (int i = 0; i <= RD_LATENCY; i++) w_inflight = w_inflight + int'(r_vld_pipe[i]);
      w_credit_ok = (int'(w_fifo_cnt) + w_inflight - int'(w_pop)) < FIFO_DEPTH;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, issue decision and done generation
   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_tag_last   = 1'b0;
      w_issue_addr = r_addr;
      w_done_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  // First read goes out on the accept edge; pipe is empty here
                  w_issue      = 1'b1;
                  w_issue_addr = bus.base_addr;
                  w_tag_last   = (bus.len == LEN_W'(1));
                  w_state_nxt  = w_tag_last ? DRAIN : FETCH;
               end
            end
         end
         FETCH: begin
            if (w_credit_ok) begin
               w_issue    = 1'b1;
               w_tag_last = (r_remain == LEN_W'(1));
               if (w_tag_last) w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_pop && w_head[DATA_WIDTH]) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address sequencing, remaining count, tag pipe and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr      <= '0;
         r_addrb     <= '0;
         r_remain    <= '0;
         r_done      <= 1'b0;
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_done      <= w_done_nxt;
         r_vld_pipe  <= {r_vld_pipe[RD_LATENCY-1:0], w_issue};
         r_last_pipe <= {r_last_pipe[RD_LATENCY-1:0], w_issue & w_tag_last};
         if (w_issue) begin
            r_addrb  <= w_issue_addr;
            r_addr   <= addr_inc(w_issue_addr);
            r_remain <= (r_state == IDLE) ? bus.len - LEN_W'(1) : r_remain - LEN_W'(1);
         end
      end
   end

   fetch_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_vld_pipe[RD_LATENCY]),
      .i_din   ({r_last_pipe[RD_LATENCY], bus.rd_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_fifo_cnt)
   );

   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.addrb     = r_addrb;
   assign bus.out_valid = ~w_empty;
   assign bus.out_data  = w_head[DATA_WIDTH-1:0];
   assign bus.out_last  = w_head[DATA_WIDTH];

   a_fifo_bound: assert property (@(posedge clk) disable iff (rst)
      (int'(w_fifo_cnt) <= FIFO_DEPTH) && !(w_full && r_vld_pipe[RD_LATENCY]));

endmodule
